// File: rtl/int_float_converter.sv
// Multi-cycle converter between signed int32 and IEEE-754 single precision.
// One bit of normalisation or denormalisation per SHIFT cycle; special cases bypass SHIFT.
module int_float_converter (
  input  logic        CLK,
  input  logic        RESET_N,
  input  logic        start,
  input  logic        op,
  input  logic [31:0] operand,
  output logic        busy,
  output logic        done,
  output logic [31:0] result,
  output logic        exception
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    PACK  = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic        op_q, op_d;
  logic        sign_q, sign_d;
  logic [7:0]  exp_q, exp_d;
  logic [31:0] mag_q, mag_d;
  logic [4:0]  cnt_q, cnt_d;
  logic        byp_q, byp_d;
  logic        byp_exc_q, byp_exc_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic [31:0] result_q, result_d;
  logic        exception_q, exception_d;

  logic [7:0]  in_exp_s;
  logic [31:0] in_abs_s;
  logic        in_byp_s;
  logic [31:0] in_byp_res_s;
  logic        in_byp_exc_s;

  assign in_exp_s = operand[30:23];
  assign in_abs_s = operand[31] ? (~operand + 32'd1) : operand;

  // Classify the incoming operand into cases that complete without shifting.
  always_comb begin
    in_byp_s     = 1'b0;
    in_byp_res_s = 32'h0000_0000;
    in_byp_exc_s = 1'b0;
    if (op == 1'b0) begin
      in_byp_s = (operand == 32'h0000_0000);
    end else if (in_exp_s == 8'd255) begin
      in_byp_s     = 1'b1;
      in_byp_exc_s = 1'b1;
    end else if (in_exp_s < 8'd127) begin
      in_byp_s = 1'b1;
    end else if (operand == 32'hCF00_0000) begin
      // -2^31 is the one e=158 value that is representable.
      in_byp_s     = 1'b1;
      in_byp_res_s = 32'h8000_0000;
    end else if (in_exp_s >= 8'd158) begin
      in_byp_s     = 1'b1;
      in_byp_exc_s = 1'b1;
      in_byp_res_s = operand[31] ? 32'h8000_0000 : 32'h7FFF_FFFF;
    end else begin
      in_byp_s = 1'b0;
    end
  end

  // State and datapath registers.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q     <= IDLE;
      op_q        <= 1'b0;
      sign_q      <= 1'b0;
      exp_q       <= 8'd0;
      mag_q       <= 32'h0000_0000;
      cnt_q       <= 5'd0;
      byp_q       <= 1'b0;
      byp_exc_q   <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      result_q    <= 32'h0000_0000;
      exception_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      sign_q      <= sign_d;
      exp_q       <= exp_d;
      mag_q       <= mag_d;
      cnt_q       <= cnt_d;
      byp_q       <= byp_d;
      byp_exc_q   <= byp_exc_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      result_q    <= result_d;
      exception_q <= exception_d;
    end
  end

  // Next-state logic: the SHIFT exit is taken on the cycle whose shift completes the work.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          if (in_byp_s || ((op == 1'b0) && in_abs_s[31])) begin
            state_d = PACK;
          end else begin
            state_d = SHIFT;
          end
        end else begin
          state_d = IDLE;
        end
      end
      SHIFT: begin
        if (op_q == 1'b0) begin
          state_d = mag_q[30] ? PACK : SHIFT;
        end else begin
          state_d = (cnt_q == 5'd1) ? PACK : SHIFT;
        end
      end
      PACK:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath and registered outputs.
  always_comb begin
    op_d        = op_q;
    sign_d      = sign_q;
    exp_d       = exp_q;
    mag_d       = mag_q;
    cnt_d       = cnt_q;
    byp_d       = byp_q;
    byp_exc_d   = byp_exc_q;
    done_d      = 1'b0;
    result_d    = result_q;
    exception_d = exception_q;
    busy_d      = (state_d != IDLE);
    case (state_q)
      IDLE: begin
        if (start) begin
          op_d      = op;
          sign_d    = operand[31];
          byp_d     = in_byp_s;
          byp_exc_d = in_byp_exc_s;
          exp_d     = (op == 1'b0) ? 8'd158 : in_exp_s;
          cnt_d     = 5'(8'd158 - in_exp_s);
          if (in_byp_s) begin
            mag_d = in_byp_res_s;
          end else if (op == 1'b0) begin
            mag_d = in_abs_s;
          end else begin
            mag_d = {1'b1, operand[22:0], 8'h00};
          end
        end else begin
          mag_d = mag_q;
        end
      end
      SHIFT: begin
        if (op_q == 1'b0) begin
          mag_d = {mag_q[30:0], 1'b0};
          exp_d = exp_q - 8'd1;
        end else begin
          mag_d = {1'b0, mag_q[31:1]};
          cnt_d = cnt_q - 5'd1;
        end
      end
      PACK: begin
        done_d = 1'b1;
        if (byp_q) begin
          result_d    = mag_q;
          exception_d = byp_exc_q;
        end else if (op_q == 1'b0) begin
          result_d    = {sign_q, exp_q, mag_q[30:8]};
          exception_d = 1'b0;
        end else begin
          result_d    = sign_q ? (~mag_q + 32'd1) : mag_q;
          exception_d = 1'b0;
        end
      end
      default: begin
        done_d = 1'b0;
      end
    endcase
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign result    = result_q;
  assign exception = exception_q;

endmodule

// File: tb/tb_int_float_converter.sv
// Self-checking bench for int_float_converter: directed corner vectors plus random
// operands checked against an arithmetic reference model.
module tb_int_float_converter;

  logic        CLK;
  logic        RESET_N;
  logic        start;
  logic        op;
  logic [31:0] operand;
  logic        busy;
  logic        done;
  logic [31:0] result;
  logic        exception;

  int total  = 0;
  int passed = 0;

  int_float_converter dut (
    .CLK       (CLK),
    .RESET_N   (RESET_N),
    .start     (start),
    .op        (op),
    .operand   (operand),
    .busy      (busy),
    .done      (done),
    .result    (result),
    .exception (exception)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) begin
      passed++;
    end else begin
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference model: value-level arithmetic, latency from the leading-bit position.
  task automatic model(input logic o, input logic [31:0] v,
                       output logic [31:0] r, output logic x, output int lat);
    longint m;
    longint frac;
    int     p;
    int     e;
    real    val;
    int     iv;
    r = 32'h0; x = 1'b0; lat = 2;
    if (o == 1'b0) begin
      if (v != 32'h0) begin
        m = longint'(v);
        if (v[31]) m = 64'h1_0000_0000 - m;
        p = 0;
        for (int i = 0; i < 32; i++) if (m >= (64'd1 << i)) p = i;
        frac = ((m - (64'd1 << p)) << 23) >> p;
        r    = {v[31], 8'(127 + p), frac[22:0]};
        lat  = 33 - p;
      end
    end else begin
      e = int'(v[30:23]);
      if (e == 255) begin
        x = 1'b1;
      end else if (e < 127) begin
        x = 1'b0;
      end else if (v == 32'hCF00_0000) begin
        r = 32'h8000_0000;
      end else if (e >= 158) begin
        x = 1'b1;
        r = v[31] ? 32'h8000_0000 : 32'h7FFF_FFFF;
      end else begin
        val = 1.0 + real'(v[22:0]) / 8388608.0;
        for (int i = 127; i < e; i++) val = val * 2.0;
        iv  = $rtoi(val);
        r   = v[31] ? (32'h0 - 32'(iv)) : 32'(iv);
        lat = 160 - e;
      end
    end
  endtask

  // One conversion; inj>0 pulses a competing start just before edge inj.
  task automatic run(input logic o, input logic [31:0] v, input int inj);
    logic [31:0] er;
    logic        ex;
    int          el;
    int          n;
    bit          got;
    model(o, v, er, ex, el);
    op = o; operand = v; start = 1'b1;
    @(posedge CLK); #1;
    start = 1'b0; op = 1'($urandom); operand = $urandom;
    n = 1;
    chk("busy_edge1", 32'(busy), 32'd1);
    chk("done_edge1", 32'(done), 32'd0);
    got = 1'b0;
    while (!got && n < 40) begin
      if (inj > 0 && n == inj - 1) begin
        start = 1'b1; op = 1'b1; operand = 32'h3F80_0000;
      end
      @(posedge CLK); #1;
      n++;
      start = 1'b0;
      if (done) got = 1'b1;
    end
    chk("done_seen", 32'(got), 32'd1);
    chk($sformatf("latency op%0d %h", o, v), 32'(n), 32'(el));
    chk($sformatf("result op%0d %h", o, v), result, er);
    chk($sformatf("exception op%0d %h", o, v), 32'(exception), 32'(ex));
    chk("busy_at_done", 32'(busy), 32'd0);
  endtask

  initial begin
    int  n;
    bit  seen;
    logic [31:0] rv;
    RESET_N = 1'b0; start = 1'b0; op = 1'b0; operand = 32'h0;
    #12;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_result", result, 32'h0);
    chk("rst_exception", 32'(exception), 32'd0);
    @(negedge CLK); RESET_N = 1'b1;

    run(1'b0, 32'h0000_0001, 0);
    run(1'b0, 32'h0000_0000, 0);
    run(1'b0, 32'hFFFF_FFFB, 0);
    run(1'b0, 32'h8000_0000, 0);
    run(1'b0, 32'h7FFF_FFFF, 0);
    run(1'b1, 32'hC049_0FDB, 0);
    run(1'b1, 32'h3F80_0000, 0);
    run(1'b1, 32'h7F80_0000, 0);
    run(1'b1, 32'h4F00_0000, 0);
    run(1'b1, 32'hCF00_0000, 0);
    run(1'b1, 32'h3F00_0000, 0);
    run(1'b1, 32'hFF80_0001, 0);
    run(1'b1, 32'h0000_0001, 0);
    run(1'b1, 32'h4EFF_FFFF, 0);

    // Competing start at edge 5 is ignored; back-to-back start during done is accepted.
    run(1'b0, 32'h0000_0001, 5);
    run(1'b0, 32'hFFFF_FFFB, 0);

    for (int i = 0; i < 30; i++) begin
      rv = $urandom;
      if (i % 3 == 0) rv = rv >> $urandom_range(31, 0);
      run(1'b0, rv, 0);
    end
    for (int i = 0; i < 30; i++) begin
      rv = $urandom;
      rv[30:23] = 8'($urandom_range(163, 122));
      run(1'b1, rv, 0);
    end

    // Reset in the middle of a long conversion.
    op = 1'b0; operand = 32'h0000_0001; start = 1'b1;
    @(posedge CLK); #1; start = 1'b0;
    for (n = 1; n < 10; n++) begin
      @(posedge CLK); #1;
    end
    RESET_N = 1'b0;
    #1;
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_done", 32'(done), 32'd0);
    chk("midrst_result", result, 32'h0);
    chk("midrst_exception", 32'(exception), 32'd0);
    @(negedge CLK); @(negedge CLK); RESET_N = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(posedge CLK); #1;
      if (done) seen = 1'b1;
    end
    chk("no_done_after_rst", 32'(seen), 32'd0);
    run(1'b0, 32'h0000_0001, 0);
    run(1'b1, 32'hC049_0FDB, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
